decryption_scheduler: RTL and testbench



---
 rtl/decryption_pkg.sv | 20 ++
 rtl/decryption_out_mux.sv | 38 +++
 rtl/decryption_scheduler.sv | 159 +++++++++++++++
 tb/tb_decryption_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/decryption_pkg.sv
// Shared constants and FSM encoding for the decryption scheduler and its helpers.
package decryption_pkg;

  localparam int D_WIDTH_DEFAULT = 8;

  localparam int CAESAR  = 0;
  localparam int SCYTALE = 1;
  localparam int ZIGZAG  = 2;

  localparam logic [7:0] START_DECRYPTION_TOKEN = 8'hFA;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    WAIT_START = 3'd2,
    DRAIN      = 3'd3,
    DISCARD    = 3'd4
  } state_t;

endpackage

// File: rtl/decryption_out_mux.sv
// Registered N:1 selection of engine outputs; data_o holds its value between valid beats.
module decryption_out_mux #(
  parameter int D_WIDTH     = 8,
  parameter int NOF_ENGINES = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [1:0]                     sel,
  input  logic [NOF_ENGINES*D_WIDTH-1:0] eng_data_i,
  input  logic [NOF_ENGINES-1:0]         eng_valid_i,
  output logic [D_WIDTH-1:0]             data_o,
  output logic                           valid_o
);
  import decryption_pkg::*;

  localparam logic [NOF_ENGINES-1:0] ONE_HOT0 = NOF_ENGINES'(1);

  logic take;

  assign take = en && (|(eng_valid_i & (ONE_HOT0 << sel)));

  // Capture the selected engine's character one cycle after its valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= take;
      if (take) begin
        data_o <= eng_data_i[sel*D_WIDTH +: D_WIDTH];
      end else begin
        data_o <= data_o;
      end
    end
  end

endmodule

// File: rtl/decryption_scheduler.sv
// Collects a message, broadcasts it to one decryption engine, then drains that engine's output.
module decryption_scheduler #(
  parameter int                 D_WIDTH                = decryption_pkg::D_WIDTH_DEFAULT,
  parameter int                 NOF_ENGINES            = 3,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(decryption_pkg::START_DECRYPTION_TOKEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [D_WIDTH-1:0]             data_i,
  input  logic                           valid_i,
  input  logic [1:0]                     sel_i,
  output logic                           ready_o,
  output logic [D_WIDTH-1:0]             eng_data_o,
  output logic [NOF_ENGINES-1:0]         eng_valid_o,
  input  logic [NOF_ENGINES-1:0]         eng_busy_i,
  input  logic [NOF_ENGINES*D_WIDTH-1:0] eng_data_i,
  input  logic [NOF_ENGINES-1:0]         eng_valid_i,
  output logic [D_WIDTH-1:0]             data_o,
  output logic                           valid_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);
  import decryption_pkg::*;

  localparam int                     CW       = $clog2(MAX_NOF_CHARS + 1);
  localparam logic [CW-1:0]          MAX_CNT  = CW'(MAX_NOF_CHARS);
  localparam logic [2:0]             N_ENG    = 3'(NOF_ENGINES);
  localparam logic [NOF_ENGINES-1:0] ONE_HOT0 = NOF_ENGINES'(1);

  state_t                   state, state_n;
  logic [CW-1:0]            cnt, cnt_n, out_cnt, out_cnt_n;
  logic [1:0]               cur_sel, cur_sel_n, fwd_sel;
  logic [NOF_ENGINES-1:0]   sel_mask;
  logic                     accept, is_token, sel_bad, sel_busy, sel_valid, busy_prev;
  logic                     fwd, err_next, done_next;

  assign ready_o   = (state == IDLE) || (state == LOAD) || (state == DISCARD);
  assign busy_o    = (state == LOAD) || (state == WAIT_START) || (state == DRAIN);
  assign accept    = valid_i && ready_o;
  assign is_token  = (data_i == START_DECRYPTION_TOKEN);
  assign sel_bad   = ({1'b0, sel_i} >= N_ENG);
  assign sel_mask  = ONE_HOT0 << cur_sel;
  assign sel_busy  = |(eng_busy_i & sel_mask);
  assign sel_valid = |(eng_valid_i & sel_mask);
  assign fwd_sel   = (state == IDLE) ? sel_i : cur_sel;

  // Next-state, counters and pulse generation.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    out_cnt_n = out_cnt;
    cur_sel_n = cur_sel;
    fwd       = 1'b0;
    err_next  = 1'b0;
    done_next = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_token) begin
          err_next = 1'b1;
        end else if (accept && sel_bad) begin
          err_next = 1'b1;
          state_n  = DISCARD;
        end else if (accept) begin
          cur_sel_n = sel_i;
          fwd       = 1'b1;
          cnt_n     = CW'(1);
          out_cnt_n = '0;
          state_n   = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (accept && is_token) begin
          fwd     = 1'b1;
          state_n = WAIT_START;
        end else if (accept && (cnt < MAX_CNT)) begin
          fwd   = 1'b1;
          cnt_n = cnt + CW'(1);
        end else if (accept) begin
          err_next = 1'b1;
        end else begin
          state_n = LOAD;
        end
      end
      WAIT_START: begin
        state_n = sel_busy ? DRAIN : WAIT_START;
      end
      DRAIN: begin
        if (sel_valid && (out_cnt < MAX_CNT)) begin
          out_cnt_n = out_cnt + CW'(1);
        end else begin
          out_cnt_n = out_cnt;
        end
        // Exit on the falling edge of the selected engine's busy.
        if (busy_prev && !sel_busy) begin
          done_next = 1'b1;
          err_next  = (out_cnt_n != cnt);
          state_n   = IDLE;
        end else begin
          state_n = DRAIN;
        end
      end
      DISCARD: begin
        state_n = (accept && is_token) ? IDLE : DISCARD;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    if (busy_o && (|(eng_valid_i & ~sel_mask))) begin
      err_next = 1'b1;
    end else begin
      err_next = err_next;
    end
  end

  // State, counters and registered engine-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_cnt     <= '0;
      cur_sel     <= 2'd0;
      busy_prev   <= 1'b0;
      eng_valid_o <= '0;
      eng_data_o  <= '0;
      err_o       <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      out_cnt     <= out_cnt_n;
      cur_sel     <= cur_sel_n;
      busy_prev   <= sel_busy;
      eng_valid_o <= fwd ? (ONE_HOT0 << fwd_sel) : '0;
      eng_data_o  <= fwd ? data_i : eng_data_o;
      err_o       <= err_next;
      done_o      <= done_next;
    end
  end

  decryption_out_mux #(
    .D_WIDTH     (D_WIDTH),
    .NOF_ENGINES (NOF_ENGINES)
  ) u_out_mux (
    .clk         (clk),
    .rst         (rst),
    .en          (state == DRAIN),
    .sel         (cur_sel),
    .eng_data_i  (eng_data_i),
    .eng_valid_i (eng_valid_i),
    .data_o      (data_o),
    .valid_o     (valid_o)
  );

endmodule

// File: tb/tb_decryption_scheduler.sv
// Scoreboard bench: the driver predicts forwards, engine outputs, done and error counts; a monitor checks them.
module tb_decryption_scheduler;
  localparam int         NE  = 3;
  localparam int         MAXC = 50;
  localparam logic [7:0] TOK = 8'hFA;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    data_i;
  logic          valid_i;
  logic [1:0]    sel_i;
  logic          ready_o;
  logic [7:0]    eng_data_o;
  logic [NE-1:0] eng_valid_o;
  logic [NE-1:0] eng_busy_i;
  logic [NE*8-1:0] eng_data_i;
  logic [NE-1:0] eng_valid_i;
  logic [7:0]    data_o;
  logic          valid_o, busy_o, done_o, err_o;

  decryption_scheduler dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .sel_i(sel_i),
    .ready_o(ready_o), .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o),
    .eng_busy_i(eng_busy_i), .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i),
    .data_o(data_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [7:0] d; int eng; } item_t;
  item_t      exp_fwd[$];
  item_t      exp_out[$];
  bit         exp_done[$];
  logic [7:0] msg[$];
  int         checks = 0;
  int         errors = 0;
  int         err_seen = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin : monitor
    item_t      it;
    logic [7:0] last_data;
    last_data = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_data = 8'd0;
      end else begin
        if (eng_valid_o != '0) begin
          if (exp_fwd.size() == 0) chk(1'b0, "fwd_unexpected", int'(eng_valid_o), 0);
          else begin
            it = exp_fwd.pop_front();
            chk(eng_valid_o == 3'(1 << it.eng), "fwd_strobe", int'(eng_valid_o), 1 << it.eng);
            chk(eng_data_o == it.d, "fwd_data", int'(eng_data_o), int'(it.d));
            chk(cyc == it.cyc, "fwd_latency", cyc, it.cyc);
          end
        end
        if (valid_o) begin
          if (exp_out.size() == 0) chk(1'b0, "out_unexpected", int'(data_o), 0);
          else begin
            it = exp_out.pop_front();
            chk(data_o == it.d, "out_data", int'(data_o), int'(it.d));
            chk(cyc == it.cyc, "out_latency", cyc, it.cyc);
          end
        end else begin
          chk(data_o == last_data, "out_hold", int'(data_o), int'(last_data));
        end
        last_data = data_o;
        if (err_o) err_seen++;
        if (done_o) begin
          if (exp_done.size() == 0) chk(1'b0, "done_unexpected", 1, 0);
          else chk(err_o == exp_done.pop_front(), "done_err_flag", int'(err_o), int'(!err_o));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int eng, input bit expect_fwd);
    valid_i = 1'b1;
    data_i  = d;
    if (expect_fwd) exp_fwd.push_back('{cyc + 1, d, eng});
    step();
    valid_i = 1'b0;
  endtask

  task automatic fill_random(input int n);
    logic [7:0] c;
    msg.delete();
    for (int i = 0; i < n; i++) begin
      do c = 8'($urandom_range(0, 255)); while (c == TOK);
      msg.push_back(c);
    end
  endtask

  // Sends msg to engine sel, plays the engine, then checks the message-level results.
  task automatic run_msg(input int sel, input int drop, input bit foreign);
    int         e0, exp_err, n, nf, n_emit, other;
    bit         ok_msg;
    logic [7:0] o;
    e0      = err_seen;
    n       = msg.size();
    ok_msg  = (n > 0) && (sel < NE);
    exp_err = ok_msg ? 0 : 1;
    nf      = (n > MAXC) ? MAXC : n;
    other   = (sel + 1) % NE;
    sel_i   = 2'(sel);
    for (int i = 0; i < n; i++) begin
      send(msg[i], sel, ok_msg && (i < MAXC));
      if (ok_msg && i >= MAXC) exp_err++;
      sel_i = 2'($urandom_range(0, 3));
    end
    send(TOK, sel, ok_msg);
    if (ok_msg) begin
      chk(ready_o == 1'b0, "ready_after_token", int'(ready_o), 0);
      chk(busy_o == 1'b1, "busy_after_token", int'(busy_o), 1);
      valid_i = 1'b1;
      data_i  = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 3)) step();
      valid_i = 1'b0;
      eng_busy_i[sel] = 1'b1;
      step();
      n_emit = nf - drop;
      for (int i = 0; i < n_emit; i++) begin
        if (foreign && i == n_emit / 2) begin
          eng_valid_i[other] = 1'b1;
          eng_data_i[other*8 +: 8] = 8'h5A;
          exp_err++;
          step();
          eng_valid_i = '0;
        end
        o = msg[i] ^ 8'h20;
        eng_valid_i[sel] = 1'b1;
        eng_data_i[sel*8 +: 8] = o;
        exp_out.push_back('{cyc + 1, o, sel});
        step();
        eng_valid_i = '0;
        if ($urandom_range(0, 1) == 1) step();
      end
      exp_done.push_back(drop != 0);
      if (drop != 0) exp_err++;
      eng_busy_i = '0;
    end
    repeat (3) step();
    chk(err_seen - e0 == exp_err, "err_count", err_seen - e0, exp_err);
    chk(exp_fwd.size() == 0, "fwd_pending", exp_fwd.size(), 0);
    chk(exp_out.size() == 0, "out_pending", exp_out.size(), 0);
    chk(exp_done.size() == 0, "done_pending", exp_done.size(), 0);
    chk(ready_o == 1'b1, "ready_end", int'(ready_o), 1);
    chk(busy_o == 1'b0, "busy_end", int'(busy_o), 0);
  endtask

  initial begin : driver
    int e0;
    rst = 1'b1; data_i = 8'd0; valid_i = 1'b0; sel_i = 2'd0;
    eng_busy_i = '0; eng_data_i = '0; eng_valid_i = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk(ready_o == 1'b1, "rst_ready", int'(ready_o), 1);
    chk(busy_o == 1'b0, "rst_busy", int'(busy_o), 0);
    chk(eng_valid_o == '0, "rst_eng_valid", int'(eng_valid_o), 0);
    chk(data_o == 8'd0 && valid_o == 1'b0, "rst_out", int'(data_o), 0);
    chk(done_o == 1'b0 && err_o == 1'b0, "rst_pulses", int'({done_o, err_o}), 0);

    msg = '{8'h41, 8'h42, 8'h43, 8'h44};
    run_msg(2, 0, 1'b0);
    msg.delete();
    run_msg(0, 0, 1'b0);
    fill_random(52); run_msg(0, 0, 1'b0);
    fill_random(50); run_msg(1, 0, 1'b0);
    fill_random(51); run_msg(2, 0, 1'b0);
    msg = '{8'h58, 8'h59};
    run_msg(3, 0, 1'b0);

    e0 = err_seen;
    eng_valid_i[0] = 1'b1; eng_data_i[7:0] = 8'h77;
    step();
    eng_valid_i = '0;
    repeat (2) step();
    chk(err_seen == e0, "idle_foreign_no_err", err_seen - e0, 0);
    fill_random(5); run_msg(1, 0, 1'b1);

    e0 = err_seen;
    sel_i = 2'd1;
    send(8'h41, 1, 1'b1);
    send(8'h42, 1, 1'b1);
    send(8'h43, 1, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk(eng_valid_o == '0, "arst_eng_valid", int'(eng_valid_o), 0);
    chk(eng_data_o == 8'd0, "arst_eng_data", int'(eng_data_o), 0);
    chk(busy_o == 1'b0 && ready_o == 1'b1, "arst_busy_ready", int'({busy_o, ready_o}), 1);
    chk(data_o == 8'd0 && valid_o == 1'b0 && done_o == 1'b0 && err_o == 1'b0,
        "arst_outputs", int'({data_o, valid_o, done_o, err_o}), 0);
    repeat (2) step();
    rst = 1'b0;
    step();
    chk(err_seen == e0, "arst_no_err", err_seen - e0, 0);
    fill_random(4); run_msg(0, 0, 1'b0);

    fill_random(6); run_msg(2, 1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      fill_random(($urandom_range(0, 7) == 0) ? $urandom_range(48, 53) : $urandom_range(0, 8));
      run_msg($urandom_range(0, 3), (msg.size() > 1) ? $urandom_range(0, 1) : 0,
              (msg.size() > 1) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
